regfile_wb: RTL



---
 rtl/regfile_wb.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// Integer register file on the receiving end of the writeback interface.
// Two combinational decode read ports with write-to-read bypass, a registered
// debug read port, and a counter of architectural (non-x0) register writes.
module regfile_wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reg_wew,
    input  logic [REG_ADDR_WIDTH-1:0] rdw,
    input  logic [DATA_WIDTH-1:0]     result,
    input  logic [REG_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2d,
    output logic [DATA_WIDTH-1:0]     rd1,
    output logic [DATA_WIDTH-1:0]     rd2,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_data,
    output logic [CNT_WIDTH-1:0]      wr_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    // x0 is hardwired to zero, so storage starts at x1.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] dbg_next;

    assign wr_commit = reg_wew && (rdw != '0);

    // Architectural register storage; reset clears every register in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[rdw] <= result;
        end
    end

    // Decode read ports: x0 reads zero, then the in-flight WB value wins over
    // storage so decode sees a cycle-N write in cycle N. Bypass is not gated by
    // rst on purpose; the read path is purely combinational.
    always_comb begin
        rd1 = '0;
        if (rs1d != '0) begin
            rd1 = (reg_wew && (rdw == rs1d)) ? result : regs[rs1d];
        end
    end

    // Same selection for read port 2.
    always_comb begin
        rd2 = '0;
        if (rs2d != '0) begin
            rd2 = (reg_wew && (rdw == rs2d)) ? result : regs[rs2d];
        end
    end

    // Debug read value before the output register, same x0/bypass rules.
    always_comb begin
        dbg_next = '0;
        if (dbg_addr != '0) begin
            dbg_next = (reg_wew && (rdw == dbg_addr)) ? result : regs[dbg_addr];
        end
    end

    // Debug output register: one cycle of latency from dbg_addr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= dbg_next;
        end
    end

    // Commit counter of writes to x1 and above; wraps freely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt <= '0;
        end else if (wr_commit) begin
            wr_cnt <= wr_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
